// File: rtl/mac_seq_ctrl.sv
// Wishbone-programmable sequencer that streams up to 16 signed operand pairs
// into the external MAC and captures the accumulator into a RESULT register.
module mac_seq_ctrl #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned MAC_LAT  = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        mac_clr,
    output logic        mac_en,
    output logic [7:0]  mac_a,
    output logic [7:0]  mac_b,
    input  logic [31:0] mac_acc_i,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(MAC_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [4:0]  len_q;
    logic [31:0] result_q;
    logic        done_q, err_q, ie_q;
    logic        ack_q;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  bufA_q [16];
    logic [7:0]  bufB_q [16];

    logic        hit, accept, wrAcc, rdAcc;
    logic        isCtrl, isLen, isResult, isBuf;
    logic [3:0]  bufIdx;
    logic [3:0]  lastIdx;
    logic        busy, lenOk;
    logic        startReq, startGo, startBad, clrReq;
    logic        capture;
    logic        unusedInputs;

    // Byte selects and the upper write-data half carry no information here.
    assign unusedInputs = ^{wbs_sel_i, wbs_dat_i[31:16]};

    assign hit      = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign accept   = wbs_cyc_i & wbs_stb_i & ~ack_q & hit;
    assign wrAcc    = accept & wbs_we_i;
    assign rdAcc    = accept & ~wbs_we_i;

    assign isCtrl   = (wbs_adr_i[7:0] == 8'h00);
    assign isLen    = (wbs_adr_i[7:0] == 8'h04);
    assign isResult = (wbs_adr_i[7:0] == 8'h08);
    assign isBuf    = (wbs_adr_i[7:6] == 2'b01) && (wbs_adr_i[1:0] == 2'b00);
    assign bufIdx   = wbs_adr_i[5:2];

    assign busy     = (state_q != IDLE);
    assign lenOk    = (len_q != 5'd0) && (len_q <= 5'd16);
    assign lastIdx  = len_q[3:0] - 4'd1;

    // START wins over CLR_DONE when both bits arrive in the same write.
    assign startReq = wrAcc & isCtrl & wbs_dat_i[0];
    assign startGo  = startReq & ~busy & lenOk;
    assign startBad = startReq & ~busy & ~lenOk;
    assign clrReq   = wrAcc & isCtrl & wbs_dat_i[1] & ~wbs_dat_i[0];

    always_comb begin
        dat_d = '0;
        if (rdAcc) begin
            if (isCtrl) begin
                dat_d = {28'd0, ie_q, err_q, done_q, busy};
            end else if (isLen) begin
                dat_d = {27'd0, len_q};
            end else if (isResult) begin
                dat_d = result_q;
            end else if (isBuf) begin
                dat_d = {16'd0, bufB_q[bufIdx], bufA_q[bufIdx]};
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= accept;
            dat_q <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            len_q <= '0;
            for (int i = 0; i < 16; i++) begin
                bufA_q[i] <= '0;
                bufB_q[i] <= '0;
            end
        end else if (wrAcc && !busy) begin
            if (isLen) begin
                len_q <= wbs_dat_i[4:0];
            end
            if (isBuf) begin
                bufA_q[bufIdx] <= wbs_dat_i[7:0];
                bufB_q[bufIdx] <= wbs_dat_i[15:8];
            end
        end
    end

    // A capture that coincides with a CLR_DONE write leaves done set.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ie_q     <= 1'b0;
            result_q <= '0;
        end else begin
            if (wrAcc && isCtrl) begin
                ie_q <= wbs_dat_i[3];
            end
            if (startGo || clrReq) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (startBad) begin
                err_q <= 1'b1;
            end
            if (capture) begin
                result_q <= mac_acc_i;
                done_q   <= 1'b1;
            end
        end
    end

    assign irq = done_q & ie_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        mac_a   = '0;
        mac_b   = '0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (startGo) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mac_clr = 1'b1;
                idx_d   = '0;
                state_d = FEED;
            end
            FEED: begin
                mac_en = 1'b1;
                mac_a  = bufA_q[idx_q];
                mac_b  = bufB_q[idx_q];
                if (idx_q == lastIdx) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == LAST_CNT) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: a register-level reference model predicts
// read data, MAC operand streams and results; monitors compare on negedges.
module tb_mac_seq_ctrl;

    localparam int          LAT    = 2;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam time         PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        macClr, macEn;
    logic [7:0]  macA, macB;
    logic [31:0] macAcc;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #(PERIOD / 2) clk = ~clk;

    mac_seq_ctrl #(.BASE_ADR(BASE), .MAC_LAT(LAT)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .mac_clr   (macClr),
        .mac_en    (macEn),
        .mac_a     (macA),
        .mac_b     (macB),
        .mac_acc_i (macAcc),
        .irq       (irq)
    );

    // Stand-in MAC: accumulate on the sampling edge, then one extra register
    // stage so the sum becomes visible two cycles after the pair is sampled.
    int accNow, accDly;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            accNow <= 0;
            accDly <= 0;
        end else begin
            if (macClr) accNow <= 0;
            else if (macEn) accNow <= accNow + int'($signed(macA)) * int'($signed(macB));
            accDly <= accNow;
        end
    end
    assign macAcc = accDly;

    // Reference model state.
    logic [4:0]         mLen;
    logic signed [7:0]  mA [16];
    logic signed [7:0]  mB [16];
    logic               mIe, mDone, mErr, mBusy;
    logic [31:0]        mResult, mPending;
    time                endTime = 0;
    bit                 startPending = 0;

    // Scoreboard queues.
    logic [31:0] expData [$];
    string       expTag  [$];
    bit          expChk  [$];
    logic [15:0] expOp   [$];
    int          expRun  [$];
    int          expClr = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic bit inWindow(input logic [31:0] a);
        return a[31:8] == BASE[31:8];
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [7:0] off;
        off = a[7:0];
        if (off == 8'h00) return {28'd0, mIe, mErr, mDone, mBusy};
        if (off == 8'h04) return {27'd0, mLen};
        if (off == 8'h08) return mResult;
        if (off >= 8'h40 && off <= 8'h7C && off[1:0] == 2'b00) return {16'd0, mB[off[5:2]], mA[off[5:2]]};
        return 32'd0;
    endfunction

    task automatic modelWrite(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] off;
        int sum;
        off = a[7:0];
        if (off == 8'h00) begin
            mIe = d[3];
            if (d[0]) begin
                if (!mBusy) begin
                    if (mLen == 0 || mLen > 16) begin
                        mErr = 1'b1;
                    end else begin
                        mDone = 1'b0;
                        mErr  = 1'b0;
                        mBusy = 1'b1;
                        sum   = 0;
                        for (int i = 0; i < int'(mLen); i++) begin
                            sum += int'(mA[i]) * int'(mB[i]);
                            expOp.push_back({mB[i], mA[i]});
                        end
                        mPending = sum;
                        expRun.push_back(int'(mLen));
                        expClr++;
                        startPending = 1;
                    end
                end
            end else if (d[1]) begin
                mDone = 1'b0;
                mErr  = 1'b0;
            end
        end else if (off == 8'h04) begin
            if (!mBusy) mLen = d[4:0];
        end else if (off >= 8'h40 && off <= 8'h7C && off[1:0] == 2'b00) begin
            if (!mBusy) begin
                mA[off[5:2]] = d[7:0];
                mB[off[5:2]] = d[15:8];
            end
        end
    endtask

    task automatic modelReset();
        mLen = 0; mIe = 0; mDone = 0; mErr = 0; mBusy = 0;
        mResult = 0; mPending = 0; startPending = 0;
        for (int i = 0; i < 16; i++) begin
            mA[i] = 0;
            mB[i] = 0;
        end
        expData.delete(); expTag.delete(); expChk.delete();
        expOp.delete(); expRun.delete(); expClr = 0;
    endtask

    // Transactions start at a negedge and leave one idle cycle after the ack.
    task automatic wbWrite(input logic [31:0] a, input logic [31:0] d);
        if (inWindow(a)) begin
            expData.push_back(32'd0);
            expTag.push_back($sformatf("wr%02h", a[7:0]));
            expChk.push_back(1'b0);
            modelWrite(a, d);
        end
        cyc = 1; stb = 1; we = 1; adr = a; wdat = d; sel = 4'hF;
        @(posedge clk);
        if (startPending) begin
            endTime = $time + (1 + int'(mLen) + LAT) * PERIOD;
            startPending = 0;
        end
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
    endtask

    task automatic wbRead(input logic [31:0] a);
        if (inWindow(a)) begin
            expData.push_back(modelRead(a));
            expTag.push_back($sformatf("rd%02h", a[7:0]));
            expChk.push_back(1'b1);
        end
        cyc = 1; stb = 1; we = 0; adr = a;
        @(posedge clk);
        @(negedge clk);
        cyc = 0; stb = 0;
        @(negedge clk);
    endtask

    task automatic waitDone();
        while ($time < endTime + PERIOD / 2) @(negedge clk);
        if (mBusy) begin
            mBusy   = 0;
            mDone   = 1;
            mResult = mPending;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "Ack"}, ack, 0);
        checkOutput({tag, "Dat"}, rdat, 0);
        checkOutput({tag, "Clr"}, macClr, 0);
        checkOutput({tag, "En"}, macEn, 0);
        checkOutput({tag, "A"}, macA, 0);
        checkOutput({tag, "B"}, macB, 0);
        checkOutput({tag, "Irq"}, irq, 0);
    endtask

    task automatic applyReset();
        #2 rst = 1;
        #1 checkIdleOutputs("rst");
        modelReset();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
    endtask

    task automatic loadRun(input int n);
        for (int i = 0; i < n; i++) wbWrite(BASE + 32'h40 + 32'(4 * i), $urandom);
        wbWrite(BASE + 32'h04, ($urandom & ~32'h1F) | 32'(n));
    endtask

    // Monitor: pops the scoreboard on every ack and follows the MAC stream.
    int          enRun = 0;
    bit          prevClr = 0;
    logic [31:0] monData;
    string       monTag;
    bit          monChk;
    always @(negedge clk) begin
        if (rst) begin
            enRun   = 0;
            prevClr = 0;
        end else begin
            if (ack) begin
                if (expData.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpectedAck actual=1 expected=0");
                end else begin
                    monData = expData.pop_front();
                    monTag  = expTag.pop_front();
                    monChk  = expChk.pop_front();
                    if (monChk) checkOutput(monTag, rdat, monData);
                end
            end else begin
                checkOutput("datNoAck", rdat, 0);
            end
            if (prevClr) checkOutput("enAfterClr", macEn, 1);
            if (macClr) begin
                checks++;
                if (expClr == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpectedClr actual=1 expected=0");
                end else begin
                    expClr--;
                end
                checkOutput("enDuringClr", macEn, 0);
            end
            if (macEn) begin
                if (expOp.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpectedEn actual=%h expected=none", {macB, macA});
                end else begin
                    checkOutput("operand", {16'd0, macB, macA}, {16'd0, expOp.pop_front()});
                end
                enRun++;
            end else if (enRun != 0) begin
                if (expRun.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpectedRun actual=%0d expected=0", enRun);
                end else begin
                    checkOutput("runLen", enRun, expRun.pop_front());
                end
                enRun = 0;
            end
            prevClr = macClr;
        end
    end

    task automatic applyStimulus();
        int n;
        logic ieBit;

        // Reset state.
        wbRead(BASE + 32'h00);
        wbRead(BASE + 32'h04);
        wbRead(BASE + 32'h08);
        wbRead(BASE + 32'h40);

        // Nominal run: 1*5 + 2*6 + 3*7 + 4*8 = 70.
        for (int i = 0; i < 4; i++) wbWrite(BASE + 32'h40 + 32'(4 * i), {16'd0, 8'(i + 5), 8'(i + 1)});
        wbWrite(BASE + 32'h04, 32'd4);
        wbWrite(BASE + 32'h00, 32'h9);
        repeat (1 + 4 + LAT - 2) @(negedge clk);
        wbRead(BASE + 32'h00);
        waitDone();
        checkOutput("nomResultModel", mResult, 32'd70);
        checkOutput("nomIrq", irq, 1);
        wbRead(BASE + 32'h00);
        wbRead(BASE + 32'h08);
        wbWrite(BASE + 32'h00, 32'hA);
        checkOutput("irqAfterClr", irq, 0);
        wbRead(BASE + 32'h00);

        // Signed extremes.
        for (int i = 0; i < 16; i++) wbWrite(BASE + 32'h40 + 32'(4 * i), 32'h8080);
        wbWrite(BASE + 32'h04, 32'd16);
        wbWrite(BASE + 32'h00, 32'h1);
        waitDone();
        checkOutput("fullResultModel", mResult, 32'd262144);
        checkOutput("fullIrqMasked", irq, 0);
        wbRead(BASE + 32'h08);
        wbWrite(BASE + 32'h40, 32'h807F);
        wbWrite(BASE + 32'h04, 32'd1);
        wbWrite(BASE + 32'h00, 32'h1);
        waitDone();
        wbRead(BASE + 32'h08);

        // Illegal lengths.
        wbWrite(BASE + 32'h00, 32'hA);
        wbWrite(BASE + 32'h04, 32'd0);
        wbWrite(BASE + 32'h00, 32'h9);
        wbRead(BASE + 32'h00);
        wbWrite(BASE + 32'h04, 32'd17);
        wbWrite(BASE + 32'h00, 32'h9);
        wbRead(BASE + 32'h00);
        checkOutput("illegalIrq", irq, 0);
        wbWrite(BASE + 32'h00, 32'h2);
        wbRead(BASE + 32'h00);

        // Busy protection: writes during FEED are acked but ignored.
        loadRun(8);
        wbWrite(BASE + 32'h00, 32'h9);
        wbWrite(BASE + 32'h00, 32'h9);
        wbWrite(BASE + 32'h04, 32'd1);
        wbWrite(BASE + 32'h40, 32'h0101);
        wbRead(BASE + 32'h00);
        waitDone();
        wbRead(BASE + 32'h04);
        wbRead(BASE + 32'h40);
        wbRead(BASE + 32'h08);
        checkOutput("busyIrq", irq, 1);
        wbWrite(BASE + 32'h00, 32'h2);

        // Bus corner cases: held strobe, unmapped offset, outside window.
        wbWrite(BASE + 32'h0C, 32'hFFFF_FFFF);
        wbRead(BASE + 32'h0C);
        expData.push_back(modelRead(BASE + 32'h04)); expTag.push_back("held1"); expChk.push_back(1);
        expData.push_back(modelRead(BASE + 32'h04)); expTag.push_back("held2"); expChk.push_back(1);
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h04;
        repeat (4) @(posedge clk);
        @(negedge clk);
        cyc = 0; stb = 0;
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h104; wdat = 32'h3;
        @(posedge clk);
        @(negedge clk);
        checkOutput("noAckOutside", ack, 0);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        wbRead(BASE + 32'h04);

        // Reset during FEED, then a clean run.
        loadRun(8);
        wbWrite(BASE + 32'h00, 32'h9);
        @(negedge clk);
        checkOutput("enBeforeRst", macEn, 1);
        applyReset();
        wbRead(BASE + 32'h08);
        wbRead(BASE + 32'h00);
        wbRead(BASE + 32'h04);
        loadRun(5);
        wbWrite(BASE + 32'h00, 32'h1);
        waitDone();
        wbRead(BASE + 32'h08);

        // Randomized runs, occasionally with an illegal length.
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 16);
            if ($urandom_range(0, 4) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 31);
            for (int i = 0; i < ((n > 16) ? 16 : n); i++) wbWrite(BASE + 32'h40 + 32'(4 * i), $urandom);
            wbWrite(BASE + 32'h04, ($urandom & ~32'h1F) | 32'(n));
            wbRead(BASE + 32'h40 + 32'(4 * $urandom_range(0, 15)));
            ieBit = 1'($urandom_range(0, 1));
            wbWrite(BASE + 32'h00, {28'd0, ieBit, 3'b001});
            if (mBusy) waitDone();
            checkOutput("randIrq", irq, mDone & mIe);
            wbRead(BASE + 32'h00);
            wbRead(BASE + 32'h08);
            wbWrite(BASE + 32'h00, {28'd0, ieBit, 3'b010});
        end
    endtask

    initial begin
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkIdleOutputs("por");
        #2 rst = 0;
        @(negedge clk);
        applyStimulus();
        repeat (4) @(negedge clk);
        checkOutput("ackQueueEmpty", expData.size(), 0);
        checkOutput("opQueueEmpty", expOp.size(), 0);
        checkOutput("runQueueEmpty", expRun.size(), 0);
        checkOutput("clrPending", expClr, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
